// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one signed shift-add multiplier between two requesters.
// Launches the job, waits for the multiplier's done (with watchdog), returns a one-cycle ack.
//
// state  | meaning
// IDLE   | no job; arbitrate pending requests
// LAUNCH | mult_start held high for START_LEN cycles
// WAIT   | waiting for a fresh mult_done or the watchdog
// RESP   | one-cycle ack to the owner with result/err
module mult_sched #(
  parameter int WIDTH     = 6,
  parameter int START_LEN = 2,
  parameter int TIMEOUT   = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req,
  input  logic [WIDTH-1:0]     x0,
  input  logic [WIDTH-1:0]     y0,
  input  logic [WIDTH-1:0]     x1,
  input  logic [WIDTH-1:0]     y1,
  output logic [1:0]           ack,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err,
  output logic                 busy,
  output logic [WIDTH-1:0]     mult_x,
  output logic [WIDTH-1:0]     mult_y,
  output logic                 mult_start,
  input  logic                 mult_done,
  input  logic [2*WIDTH-1:0]   mult_result
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [2:0]    START_LAST = 3'(START_LEN);

  state_t        state;
  logic          owner;
  logic          last_owner;
  logic          busy_seen;
  logic [2:0]    start_cnt;
  logic [TW-1:0] to_cnt;
  logic          winner;

  // Only one pending: it wins; both pending: the one not served last time.
  always_comb begin
    winner = req[1];
    if (req == 2'b11) winner = ~last_owner;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ack        <= '0;
      result     <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      mult_x     <= '0;
      mult_y     <= '0;
      mult_start <= 1'b0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      busy_seen  <= 1'b0;
      start_cnt  <= '0;
      to_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner      <= winner;
            mult_x     <= winner ? x1 : x0;
            mult_y     <= winner ? y1 : y0;
            mult_start <= 1'b1;
            start_cnt  <= 3'd1;
            busy       <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (start_cnt == START_LAST) begin
            mult_start <= 1'b0;
            busy_seen  <= 1'b0;
            to_cnt     <= '0;
            state      <= WAIT;
          end else begin
            start_cnt <= start_cnt + 3'd1;
          end
        end
        WAIT: begin
          // A done level is only trusted after the multiplier has been seen busy.
          if (mult_done && busy_seen) begin
            result <= mult_result;
            err    <= 1'b0;
            ack    <= owner ? 2'b10 : 2'b01;
            state  <= RESP;
          end else begin
            if (!mult_done) busy_seen <= 1'b1;
            if (to_cnt == TO_LAST) begin
              result <= '0;
              err    <= 1'b1;
              ack    <= owner ? 2'b10 : 2'b01;
              state  <= RESP;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        RESP: begin
          ack        <= '0;
          last_owner <= owner;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
